// File: rtl/key_timer_pkg.sv
// Shared types and round-count lookup for the AES key-schedule round sequencer.
package key_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } key_state_e;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10,
        RSVD   = 2'b11
    } key_mode_e;

    localparam int unsigned ROUNDS_AES128 = 10;
    localparam int unsigned ROUNDS_AES192 = 12;
    localparam int unsigned ROUNDS_AES256 = 14;

    // RSVD maps to 0; the caller rejects it before the value is ever used.
    function automatic int unsigned rounds_for_mode(input key_mode_e mode);
        case (mode)
            AES128:  return ROUNDS_AES128;
            AES192:  return ROUNDS_AES192;
            AES256:  return ROUNDS_AES256;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/key_sub_counter.sv
// Sub-cycle counter: counts 0..rollover_val while enabled, flags the last count as wrap.
module key_sub_counter #(
    parameter int SUB_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                enable,
    input  logic [SUB_BITS-1:0] rollover_val,
    output logic [SUB_BITS-1:0] count,
    output logic                wrap
);

    assign wrap = enable && (count == rollover_val);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + SUB_BITS'(1);
        end
    end

endmodule

// File: rtl/key_round_timer.sv
// Run-time selectable AES-128/192/256 round sequencer with stall, abort and
// a start/busy/done handshake; emits one strobe per completed round.
module key_round_timer
    import key_timer_pkg::*;
#(
    parameter int CYCLES_PER_ROUND = 1,
    parameter int SUB_BITS         = 4,
    parameter int IDX_BITS         = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                key_start,
    input  logic [1:0]          key_mode,
    input  logic                key_stall,
    input  logic                key_abort,
    output logic                key_busy,
    output logic                round_strobe,
    output logic [IDX_BITS-1:0] round_idx,
    output logic                key_done,
    output logic                mode_err,
    output logic [1:0]          state_dbg,
    output logic [SUB_BITS-1:0] sub_dbg
);

    // Handshake: key_start is a one-cycle request honoured only in IDLE; key_busy
    // rises the next cycle and stays high through DONE; key_done pulses once in DONE.
    key_state_e          state;
    logic [IDX_BITS-1:0] nrounds;
    logic                sub_clear;
    logic                sub_enable;
    logic                sub_wrap;

    assign sub_clear  = key_abort || (state != RUN);
    assign sub_enable = (state == RUN) && !key_stall && !key_abort;

    key_sub_counter #(
        .SUB_BITS(SUB_BITS)
    ) u_sub (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (sub_clear),
        .enable      (sub_enable),
        .rollover_val(SUB_BITS'(CYCLES_PER_ROUND - 1)),
        .count       (sub_dbg),
        .wrap        (sub_wrap)
    );

    assign round_strobe = sub_wrap;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            nrounds   <= '0;
            round_idx <= '0;
            key_busy  <= 1'b0;
            key_done  <= 1'b0;
            mode_err  <= 1'b0;
        end else begin
            key_done <= 1'b0;
            mode_err <= 1'b0;
            if (key_abort) begin
                state     <= IDLE;
                round_idx <= '0;
                key_busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_start) begin
                            if (key_mode == RSVD) begin
                                mode_err <= 1'b1;
                            end else begin
                                nrounds   <= IDX_BITS'(rounds_for_mode(key_mode_e'(key_mode)));
                                round_idx <= IDX_BITS'(1);
                                key_busy  <= 1'b1;
                                state     <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        // sub_wrap is already suppressed by stall, so rounds only advance on real progress.
                        if (sub_wrap) begin
                            if (round_idx == nrounds) begin
                                state    <= DONE;
                                key_done <= 1'b1;
                            end else begin
                                round_idx <= round_idx + IDX_BITS'(1);
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        round_idx <= '0;
                        key_busy  <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        round_idx <= '0;
                        key_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_round_timer.sv
// Bench for key_round_timer: two instances (1 and 4 clocks per round) share stimulus
// and are checked every cycle against a round-progress model plus literal timing checks.
module tb_key_round_timer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       key_start = 1'b0;
    logic [1:0] key_mode = 2'b00;
    logic       key_stall = 1'b0;
    logic       key_abort = 1'b0;

    logic       busy   [2];
    logic       strobe [2];
    logic       done   [2];
    logic       merr   [2];
    logic [3:0] idx    [2];
    logic [1:0] st_dbg [2];
    logic [3:0] sub_dbg[2];

    key_round_timer #(.CYCLES_PER_ROUND(1), .SUB_BITS(4), .IDX_BITS(4)) u_dut_c1 (
        .clk(clk), .n_rst(n_rst), .key_start(key_start), .key_mode(key_mode),
        .key_stall(key_stall), .key_abort(key_abort), .key_busy(busy[0]),
        .round_strobe(strobe[0]), .round_idx(idx[0]), .key_done(done[0]),
        .mode_err(merr[0]), .state_dbg(st_dbg[0]), .sub_dbg(sub_dbg[0])
    );

    key_round_timer #(.CYCLES_PER_ROUND(4), .SUB_BITS(4), .IDX_BITS(4)) u_dut_c4 (
        .clk(clk), .n_rst(n_rst), .key_start(key_start), .key_mode(key_mode),
        .key_stall(key_stall), .key_abort(key_abort), .key_busy(busy[1]),
        .round_strobe(strobe[1]), .round_idx(idx[1]), .key_done(done[1]),
        .mode_err(merr[1]), .state_dbg(st_dbg[1]), .sub_dbg(sub_dbg[1])
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int i, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, i, act, exp, cyc);
    endtask

    function automatic int cpr_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int rounds_of(input logic [1:0] m);
        case (m)
            2'd0:    return 10;
            2'd1:    return 12;
            2'd2:    return 14;
            default: return 0;
        endcase
    endfunction

    // ---------------- model ----------------
    // phase 0 idle, 1 running, 2 done; m_e counts unstalled running cycles since start.
    int m_phase[2];
    int m_e    [2];
    int m_n    [2];
    bit m_err  [2];

    always @(posedge clk or negedge n_rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!n_rst) begin
                m_phase[i] = 0; m_e[i] = 0; m_n[i] = 0; m_err[i] = 1'b0;
            end else if (key_abort) begin
                m_phase[i] = 0; m_err[i] = 1'b0;
            end else begin
                case (m_phase[i])
                    0: begin
                        m_err[i] = key_start && (key_mode == 2'd3);
                        if (key_start && key_mode != 2'd3) begin
                            m_phase[i] = 1; m_e[i] = 0; m_n[i] = rounds_of(key_mode);
                        end
                    end
                    1: begin
                        m_err[i] = 1'b0;
                        if (!key_stall) begin
                            m_e[i]++;
                            if (m_e[i] == m_n[i] * cpr_of(i)) m_phase[i] = 2;
                        end
                    end
                    default: begin
                        m_err[i] = 1'b0; m_phase[i] = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int c, e_idx;
            bit e_str;
            c = cpr_of(i);
            e_idx = (m_phase[i] == 1) ? (m_e[i] / c + 1) : (m_phase[i] == 2) ? m_n[i] : 0;
            e_str = (m_phase[i] == 1) && !key_abort && !key_stall && (m_e[i] % c == c - 1);
            check("busy",   i, busy[i],   (m_phase[i] != 0) ? 1 : 0);
            check("idx",    i, idx[i],    e_idx);
            check("done",   i, done[i],   (m_phase[i] == 2) ? 1 : 0);
            check("strobe", i, strobe[i], e_str ? 1 : 0);
            check("merr",   i, merr[i],   m_err[i] ? 1 : 0);
        end
    end

    // ---------------- event monitor ----------------
    int done_cnt[2];
    int done_cyc[2];
    int str_cnt [2];
    int fall_cyc[2];
    int str_cyc [2][16];
    bit prev_busy[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin done_cnt[i]++; done_cyc[i] = cyc; end
            if (strobe[i]) begin str_cnt[i]++; str_cyc[i][idx[i]] = cyc; end
            if (prev_busy[i] && !busy[i]) fall_cyc[i] = cyc;
            prev_busy[i] = busy[i];
        end
    end

    task automatic clr_mon();
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0; done_cyc[i] = -1000; str_cnt[i] = 0; fall_cyc[i] = -1000;
            for (int k = 0; k < 16; k++) str_cyc[i][k] = -1000;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] mode, output int t);
        key_mode  = mode;
        key_start = 1'b1;
        t = cyc;
        tick();
        key_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy[0] || busy[1]) && k < budget) begin
            tick();
            k++;
        end
        check("wait_idle_timeout", 0, (busy[0] || busy[1]) ? 1 : 0, 0);
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000ns");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        clr_mon();
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", i, busy[i], 0);
            check("rst_idx",  i, idx[i],  0);
            check("rst_done", i, done[i], 0);
            check("rst_merr", i, merr[i], 0);
        end
        n_rst = 1'b1;
        tick();

        // AES-128: 10 rounds
        clr_mon();
        start_run(2'd0, t);
        wait_idle(200);
        check("m00_strobes",  0, str_cnt[0], 10);
        check("m00_first",    0, str_cyc[0][1] - t, 1);
        check("m00_last",     0, str_cyc[0][10] - t, 10);
        check("m00_done",     0, done_cyc[0] - t, 11);
        check("m00_busyfall", 0, fall_cyc[0] - t, 12);
        check("m00_done",     1, done_cyc[1] - t, 41);

        // AES-256: 14 rounds
        clr_mon();
        start_run(2'd2, t);
        wait_idle(200);
        check("m10_strobes", 1, str_cnt[1], 14);
        check("m10_first",   1, str_cyc[1][1] - t, 4);
        check("m10_second",  1, str_cyc[1][2] - t, 8);
        check("m10_last",    1, str_cyc[1][14] - t, 56);
        check("m10_done",    1, done_cyc[1] - t, 57);
        check("m10_done",    0, done_cyc[0] - t, 15);

        // AES-192 with 3 stall cycles during round 5 of the 1-cycle instance
        clr_mon();
        start_run(2'd1, t);
        repeat (4) tick();
        key_stall = 1'b1;
        repeat (3) tick();
        key_stall = 1'b0;
        wait_idle(200);
        check("stall_r4",      0, str_cyc[0][4] - t, 4);
        check("stall_r5",      0, str_cyc[0][5] - t, 8);
        check("stall_strobes", 0, str_cnt[0], 12);
        check("stall_done",    0, done_cyc[0] - t, 16);
        check("stall_done",    1, done_cyc[1] - t, 52);

        // abort during round 7
        clr_mon();
        start_run(2'd0, t);
        repeat (6) tick();
        check("abort_pre_idx", 0, idx[0], 7);
        key_abort = 1'b1;
        tick();
        key_abort = 1'b0;
        check("abort_idx",  0, idx[0], 0);
        check("abort_busy", 0, busy[0], 0);
        check("abort_busy", 1, busy[1], 0);
        repeat (20) tick();
        check("abort_nodone", 0, done_cnt[0], 0);
        check("abort_nodone", 1, done_cnt[1], 0);
        clr_mon();
        start_run(2'd0, t);
        wait_idle(200);
        check("post_abort_done", 0, done_cyc[0] - t, 11);
        check("post_abort_cnt",  0, done_cnt[0], 1);

        // illegal mode, then start+abort together
        start_run(2'd3, t);
        check("merr_pulse", 0, merr[0], 1);
        check("merr_pulse", 1, merr[1], 1);
        check("merr_busy",  0, busy[0], 0);
        tick();
        check("merr_clear", 0, merr[0], 0);
        key_mode  = 2'd3;
        key_start = 1'b1;
        key_abort = 1'b1;
        tick();
        key_start = 1'b0;
        key_abort = 1'b0;
        check("abort_start_merr", 0, merr[0], 0);
        check("abort_start_busy", 0, busy[0], 0);

        // second start mid-run is ignored
        clr_mon();
        start_run(2'd0, t);
        repeat (4) tick();
        key_mode  = 2'd2;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        wait_idle(200);
        check("restart_strobes", 0, str_cnt[0], 10);
        check("restart_done",    0, done_cyc[0] - t, 11);
        check("restart_done",    1, done_cyc[1] - t, 41);

        // asynchronous reset mid-run
        start_run(2'd2, t);
        repeat (5) tick();
        #2;
        n_rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("arst_busy",   i, busy[i], 0);
            check("arst_idx",    i, idx[i], 0);
            check("arst_strobe", i, strobe[i], 0);
        end
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        repeat (5) tick();
        check("arst_idle_busy", 0, busy[0], 0);
        check("arst_idle_idx",  1, idx[1], 0);
        clr_mon();
        start_run(2'd0, t);
        wait_idle(200);
        check("arst_fresh_done", 0, done_cyc[0] - t, 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
